// File: rtl/scalar_reg_file_mw_pkg.sv
// Shared types and constants for the multi-warp scalar register file.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package scalar_reg_file_mw_pkg;

  localparam int DEFAULT_DATA_WIDTH = `DATA_WIDTH;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

  // Source selection for the core writeback port. LSU_OUT is never a legal
  // core writeback source; load data arrives on the dedicated LSU port.
  typedef enum logic [1:0] {
    ALU_OUT   = 2'd0,
    LSU_OUT   = 2'd1,
    IMMEDIATE = 2'd2,
    PC_PLUS_1 = 2'd3
  } reg_input_mux_t;

  localparam int ZERO_REG           = 0;
  localparam int EXECUTION_MASK_REG = 1;

  // Warp-select width; a single-warp build still carries a 1-bit warp field.
  function automatic int warp_width(input int num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

endpackage

// File: rtl/scalar_reg_file_mw_scoreboard.sv
// Pending-load scoreboard: one busy bit per (warp, register), flat-indexed.
module reg_scoreboard #(
  parameter int DEPTH = 128,
  parameter int IW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_valid,
  input  logic [IW-1:0] set_idx,
  input  logic          clr_valid,
  input  logic [IW-1:0] clr_idx,
  input  logic          chk_valid,
  input  logic [IW-1:0] chk_idx,
  input  logic [IW-1:0] lk1_idx,
  input  logic [IW-1:0] lk2_idx,
  output logic          lk1_busy,
  output logic          lk2_busy,
  output logic          err
);

  logic [DEPTH-1:0] busy;

  // Busy-bit update; the set is applied last so a same-cycle set and clear
  // of one bit leaves it set. Re-marking a busy register or writing one from
  // the core port latches the sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      if (clr_valid) busy[clr_idx] <= 1'b0;
      if (set_valid) busy[set_idx] <= 1'b1;
      if ((set_valid && busy[set_idx]) || (chk_valid && busy[chk_idx])) err <= 1'b1;
    end
  end

  assign lk1_busy = busy[lk1_idx];
  assign lk2_busy = busy[lk2_idx];

endmodule

// File: rtl/scalar_reg_file_mw.sv
// Multi-warp scalar register file with core and LSU write ports, bypassing
// and a pending-load scoreboard that stalls reads of outstanding registers.
module scalar_reg_file_mw
  import scalar_reg_file_mw_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_WARPS  = 4,
  parameter int NUM_REGS   = 32,
  parameter int PC_WIDTH   = 8,
  localparam int WW = warp_width(NUM_WARPS),
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rd_req_valid,
  input  logic [WW-1:0]                   rd_req_warp,
  input  logic [AW-1:0]                   rd_rs1_addr,
  input  logic [AW-1:0]                   rd_rs2_addr,
  output logic                            rd_req_ready,
  output logic                            rd_rsp_valid,
  output logic [DATA_WIDTH-1:0]           rs1,
  output logic [DATA_WIDTH-1:0]           rs2,
  input  logic                            wb_valid,
  input  logic [WW-1:0]                   wb_warp,
  input  logic [AW-1:0]                   wb_rd,
  input  reg_input_mux_t                  wb_mux,
  input  logic [DATA_WIDTH-1:0]           alu_out,
  input  logic [DATA_WIDTH-1:0]           immediate,
  input  logic [PC_WIDTH-1:0]             pc,
  input  logic                            pend_valid,
  input  logic [WW-1:0]                   pend_warp,
  input  logic [AW-1:0]                   pend_rd,
  input  logic                            lsu_wb_valid,
  output logic                            lsu_wb_ready,
  input  logic [WW-1:0]                   lsu_wb_warp,
  input  logic [AW-1:0]                   lsu_wb_rd,
  input  logic [DATA_WIDTH-1:0]           lsu_wb_data,
  output logic [NUM_WARPS*DATA_WIDTH-1:0] warp_execution_mask,
  output logic                            err
);

  localparam int DEPTH = NUM_WARPS * NUM_REGS;
  localparam int IW    = WW + AW;

  function automatic logic warp_ok(input logic [WW-1:0] w);
    return int'(w) < NUM_WARPS;
  endfunction

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  logic [IW-1:0]         a_idx, b_idx, pend_idx, rd_idx1, rd_idx2;
  logic [PC_WIDTH-1:0]   pc_plus_one;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  a_mux_ok;
  logic                  a_fire, b_accept, b_fire, pend_set;
  logic                  rd_ok, rd_accept;
  logic                  busy1, busy2, sb_err;
  logic                  err_event, err_q;
  logic [DATA_WIDTH-1:0] rs1_next, rs2_next;

  assign a_idx    = {wb_warp, wb_rd};
  assign b_idx    = {lsu_wb_warp, lsu_wb_rd};
  assign pend_idx = {pend_warp, pend_rd};
  assign rd_idx1  = {rd_req_warp, rd_rs1_addr};
  assign rd_idx2  = {rd_req_warp, rd_rs2_addr};

  assign pc_plus_one = pc + PC_WIDTH'(1);

  // Select the core writeback value; unsupported sources suppress the write.
  always_comb begin
    a_data   = '0;
    a_mux_ok = 1'b1;
    case (wb_mux)
      ALU_OUT:   a_data = alu_out;
      IMMEDIATE: a_data = immediate;
      PC_PLUS_1: a_data = DATA_WIDTH'(pc_plus_one);
      default:   a_mux_ok = 1'b0;
    endcase
  end

  // Only a collision on the exact same (warp, register) holds off the LSU.
  assign lsu_wb_ready = !(wb_valid && (wb_warp == lsu_wb_warp) && (wb_rd == lsu_wb_rd));

  assign a_fire   = wb_valid && warp_ok(wb_warp) && a_mux_ok && (wb_rd != AW'(ZERO_REG));
  assign b_accept = lsu_wb_valid && lsu_wb_ready && warp_ok(lsu_wb_warp);
  assign b_fire   = b_accept && (lsu_wb_rd != AW'(ZERO_REG));
  assign pend_set = pend_valid && warp_ok(pend_warp) && (pend_rd != AW'(ZERO_REG));

  assign rd_ok        = warp_ok(rd_req_warp);
  assign rd_req_ready = !(rd_ok && (busy1 || busy2));
  assign rd_accept    = rd_req_valid && rd_req_ready && rd_ok;

  reg_scoreboard #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_valid (pend_set),
    .set_idx   (pend_idx),
    .clr_valid (b_accept),
    .clr_idx   (b_idx),
    .chk_valid (a_fire),
    .chk_idx   (a_idx),
    .lk1_idx   (rd_idx1),
    .lk2_idx   (rd_idx2),
    .lk1_busy  (busy1),
    .lk2_busy  (busy2),
    .err       (sb_err)
  );

  // Read data with forwarding of both write ports; register 0 is never written
  // so it never gets forwarded either.
  always_comb begin
    rs1_next = regs[rd_idx1];
    rs2_next = regs[rd_idx2];
    if (b_fire && (b_idx == rd_idx1)) rs1_next = lsu_wb_data;
    if (b_fire && (b_idx == rd_idx2)) rs2_next = lsu_wb_data;
    if (a_fire && (a_idx == rd_idx1)) rs1_next = a_data;
    if (a_fire && (a_idx == rd_idx2)) rs2_next = a_data;
  end

  // Register storage; both ports may write distinct registers in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= ((i % NUM_REGS) == EXECUTION_MASK_REG) ? '1 : '0;
    end else begin
      if (a_fire) regs[a_idx] <= a_data;
      if (b_fire) regs[b_idx] <= lsu_wb_data;
    end
  end

  // Registered read response: one-cycle valid pulse, data held until next read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_rsp_valid <= 1'b0;
      rs1          <= '0;
      rs2          <= '0;
    end else begin
      rd_rsp_valid <= rd_accept;
      if (rd_accept) begin
        rs1 <= rs1_next;
        rs2 <= rs2_next;
      end
    end
  end

  assign err_event = (wb_valid && (!warp_ok(wb_warp) || !a_mux_ok))
                   || (pend_valid && !warp_ok(pend_warp))
                   || (lsu_wb_valid && !warp_ok(lsu_wb_warp))
                   || (rd_req_valid && !rd_ok);

  // Sticky error for illegal sources and out-of-range warps.
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else if (err_event) err_q <= 1'b1;
  end

  assign err = err_q || sb_err;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_mask
    assign warp_execution_mask[w*DATA_WIDTH +: DATA_WIDTH] = regs[w*NUM_REGS + EXECUTION_MASK_REG];
  end

endmodule

// File: tb/tb_scalar_reg_file_mw.sv
// Directed bench for scalar_reg_file_mw with a read-response scoreboard queue.
module tb_scalar_reg_file_mw;
  import scalar_reg_file_mw_pkg::*;

  localparam int DW = 32;
  localparam int NW = 4;
  localparam int NR = 32;
  localparam int PW = 8;
  localparam int WW = 2;
  localparam int AW = 5;
  localparam logic [DW-1:0] ONES = '1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 rd_req_valid;
  logic [WW-1:0]        rd_req_warp;
  logic [AW-1:0]        rd_rs1_addr, rd_rs2_addr;
  logic                 rd_req_ready, rd_rsp_valid;
  logic [DW-1:0]        rs1, rs2;
  logic                 wb_valid;
  logic [WW-1:0]        wb_warp;
  logic [AW-1:0]        wb_rd;
  reg_input_mux_t       wb_mux;
  logic [DW-1:0]        alu_out, immediate;
  logic [PW-1:0]        pc;
  logic                 pend_valid;
  logic [WW-1:0]        pend_warp;
  logic [AW-1:0]        pend_rd;
  logic                 lsu_wb_valid, lsu_wb_ready;
  logic [WW-1:0]        lsu_wb_warp;
  logic [AW-1:0]        lsu_wb_rd;
  logic [DW-1:0]        lsu_wb_data;
  logic [NW*DW-1:0]     warp_execution_mask;
  logic                 err;

  typedef struct {
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  scalar_reg_file_mw #(
    .DATA_WIDTH (DW),
    .NUM_WARPS  (NW),
    .NUM_REGS   (NR),
    .PC_WIDTH   (PW)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .rd_req_valid        (rd_req_valid),
    .rd_req_warp         (rd_req_warp),
    .rd_rs1_addr         (rd_rs1_addr),
    .rd_rs2_addr         (rd_rs2_addr),
    .rd_req_ready        (rd_req_ready),
    .rd_rsp_valid        (rd_rsp_valid),
    .rs1                 (rs1),
    .rs2                 (rs2),
    .wb_valid            (wb_valid),
    .wb_warp             (wb_warp),
    .wb_rd               (wb_rd),
    .wb_mux              (wb_mux),
    .alu_out             (alu_out),
    .immediate           (immediate),
    .pc                  (pc),
    .pend_valid          (pend_valid),
    .pend_warp           (pend_warp),
    .pend_rd             (pend_rd),
    .lsu_wb_valid        (lsu_wb_valid),
    .lsu_wb_ready        (lsu_wb_ready),
    .lsu_wb_warp         (lsu_wb_warp),
    .lsu_wb_rd           (lsu_wb_rd),
    .lsu_wb_data         (lsu_wb_data),
    .warp_execution_mask (warp_execution_mask),
    .err                 (err)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends even if the sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic idle_inputs();
    rd_req_valid = 1'b0; rd_req_warp = '0; rd_rs1_addr = '0; rd_rs2_addr = '0;
    wb_valid = 1'b0; wb_warp = '0; wb_rd = '0; wb_mux = ALU_OUT;
    alu_out = '0; immediate = '0; pc = '0;
    pend_valid = 1'b0; pend_warp = '0; pend_rd = '0;
    lsu_wb_valid = 1'b0; lsu_wb_warp = '0; lsu_wb_rd = '0; lsu_wb_data = '0;
  endtask

  // Advance one clock; any read accepted last cycle must answer now, else no pulse.
  task automatic tick();
    rsp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_output("rsp_valid", 64'(rd_rsp_valid), 64'(1));
      check_output("rs1", 64'(rs1), 64'(e.r1));
      check_output("rs2", 64'(rs2), 64'(e.r2));
    end else begin
      check_output("rsp_idle", 64'(rd_rsp_valid), 64'(0));
    end
  endtask

  task automatic set_read(input int w, input int a1, input int a2);
    rd_req_valid = 1'b1;
    rd_req_warp  = WW'(w);
    rd_rs1_addr  = AW'(a1);
    rd_rs2_addr  = AW'(a2);
  endtask

  task automatic expect_read(input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    rsp_t e;
    #1;
    check_output("rd_req_ready", 64'(rd_req_ready), 64'(1));
    e.r1 = e1;
    e.r2 = e2;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input int w, input int r, input reg_input_mux_t m, input logic [DW-1:0] v, input logic [PW-1:0] p);
    wb_valid = 1'b1; wb_warp = WW'(w); wb_rd = AW'(r); wb_mux = m;
    alu_out = v; immediate = v; pc = p;
  endtask

  task automatic plain_read(input int w, input int a1, input int a2, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    set_read(w, a1, a2);
    expect_read(e1, e2);
    tick();
    idle_inputs();
  endtask

  task automatic check_masks(input logic [DW-1:0] w2_value);
    for (int w = 0; w < NW; w++)
      check_output($sformatf("mask_w%0d", w), 64'(warp_execution_mask[w*DW +: DW]), 64'((w == 2) ? w2_value : ONES));
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    $display("[TB] reset state");
    check_output("rs1_reset", 64'(rs1), 64'(0));
    check_output("rs2_reset", 64'(rs2), 64'(0));
    check_output("err_reset", 64'(err), 64'(0));
    check_output("lsu_ready_reset", 64'(lsu_wb_ready), 64'(1));
    check_masks(ONES);

    $display("[TB] warp 2 r0/r1 read");
    plain_read(2, 0, 1, 32'h0, ONES);

    $display("[TB] core immediate write with bypass");
    apply_stimulus(1, 5, IMMEDIATE, 32'h1234, 8'h0);
    set_read(1, 5, 1);
    expect_read(32'h1234, ONES);
    tick();
    idle_inputs();
    check_output("rs1_hold", 64'(rs1), 64'(32'h1234));
    plain_read(0, 5, 5, 32'h0, 32'h0);
    plain_read(1, 5, 0, 32'h1234, 32'h0);

    $display("[TB] pending load stalls reads");
    pend_valid = 1'b1; pend_warp = 2'd3; pend_rd = 5'd7;
    tick();
    idle_inputs();
    set_read(3, 7, 0);
    #1;
    check_output("ready_busy0", 64'(rd_req_ready), 64'(0));
    tick();
    check_output("ready_busy1", 64'(rd_req_ready), 64'(0));
    lsu_wb_valid = 1'b1; lsu_wb_warp = 2'd3; lsu_wb_rd = 5'd7; lsu_wb_data = 32'hCAFE;
    #1;
    check_output("lsu_ready_free", 64'(lsu_wb_ready), 64'(1));
    check_output("ready_busy2", 64'(rd_req_ready), 64'(0));
    tick();
    lsu_wb_valid = 1'b0;
    expect_read(32'hCAFE, 32'h0);
    tick();
    idle_inputs();

    $display("[TB] same-cycle pend and return keeps the bit set");
    pend_valid = 1'b1; pend_warp = 2'd0; pend_rd = 5'd11;
    lsu_wb_valid = 1'b1; lsu_wb_warp = 2'd0; lsu_wb_rd = 5'd11; lsu_wb_data = 32'h4444;
    tick();
    idle_inputs();
    set_read(0, 0, 11);
    #1;
    check_output("ready_setclr", 64'(rd_req_ready), 64'(0));
    lsu_wb_valid = 1'b1; lsu_wb_warp = 2'd0; lsu_wb_rd = 5'd11; lsu_wb_data = 32'h5555;
    tick();
    lsu_wb_valid = 1'b0;
    expect_read(32'h0, 32'h5555);
    tick();
    idle_inputs();

    $display("[TB] port collisions");
    apply_stimulus(0, 4, ALU_OUT, 32'hAAAA5555, 8'h0);
    lsu_wb_valid = 1'b1; lsu_wb_warp = 2'd0; lsu_wb_rd = 5'd4; lsu_wb_data = 32'h11111111;
    #1;
    check_output("lsu_ready_collide", 64'(lsu_wb_ready), 64'(0));
    tick();
    idle_inputs();
    plain_read(0, 4, 0, 32'hAAAA5555, 32'h0);
    apply_stimulus(0, 4, ALU_OUT, 32'h22222222, 8'h0);
    lsu_wb_valid = 1'b1; lsu_wb_warp = 2'd0; lsu_wb_rd = 5'd6; lsu_wb_data = 32'h33333333;
    #1;
    check_output("lsu_ready_distinct", 64'(lsu_wb_ready), 64'(1));
    tick();
    idle_inputs();
    plain_read(0, 4, 6, 32'h22222222, 32'h33333333);

    $display("[TB] LSU bypass");
    lsu_wb_valid = 1'b1; lsu_wb_warp = 2'd2; lsu_wb_rd = 5'd9; lsu_wb_data = 32'h5A5A;
    set_read(2, 9, 9);
    expect_read(32'h5A5A, 32'h5A5A);
    tick();
    idle_inputs();

    $display("[TB] pc plus one");
    apply_stimulus(1, 8, IMMEDIATE, 32'hDEAD, 8'h0);
    tick();
    idle_inputs();
    apply_stimulus(1, 8, PC_PLUS_1, 32'h0, 8'hFF);
    apply_stimulus(1, 8, PC_PLUS_1, 32'h0, 8'hFF);
    tick();
    apply_stimulus(1, 9, PC_PLUS_1, 32'h0, 8'h10);
    tick();
    idle_inputs();
    plain_read(1, 8, 9, 32'h0, 32'h11);

    $display("[TB] execution mask write");
    apply_stimulus(2, 1, IMMEDIATE, 32'h0000000F, 8'h0);
    tick();
    idle_inputs();
    check_masks(32'h0000000F);
    check_output("err_clean", 64'(err), 64'(0));

    $display("[TB] illegal source and r0 write");
    apply_stimulus(0, 10, LSU_OUT, 32'hBEEF, 8'h0);
    tick();
    idle_inputs();
    check_output("err_lsu_out", 64'(err), 64'(1));
    apply_stimulus(0, 0, IMMEDIATE, 32'h77, 8'h0);
    set_read(0, 0, 10);
    expect_read(32'h0, 32'h0);
    tick();
    idle_inputs();
    plain_read(0, 0, 10, 32'h0, 32'h0);
    tick();
    check_output("err_sticky", 64'(err), 64'(1));

    $display("[TB] reset mid-operation");
    pend_valid = 1'b1; pend_warp = 2'd1; pend_rd = 5'd3;
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check_output("err_after_reset", 64'(err), 64'(0));
    check_masks(ONES);
    lsu_wb_valid = 1'b1; lsu_wb_warp = 2'd1; lsu_wb_rd = 5'd3; lsu_wb_data = 32'h99;
    tick();
    idle_inputs();
    plain_read(1, 3, 5, 32'h99, 32'h0);

    $display("[TB] pend on busy register");
    pend_valid = 1'b1; pend_warp = 2'd0; pend_rd = 5'd2;
    tick();
    check_output("err_first_pend", 64'(err), 64'(0));
    tick();
    idle_inputs();
    check_output("err_double_pend", 64'(err), 64'(1));
    set_read(0, 2, 0);
    #1;
    check_output("ready_still_busy", 64'(rd_req_ready), 64'(0));
    idle_inputs();
    tick();

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/scalar_reg_file_mw.md
# scalar_reg_file_mw

Multi-warp scalar register file: one register bank per warp, selected by warp ID, replacing per-warp register-file instances. It has two write ports: core writeback and asynchronous LSU return. A per-register pending-write scoreboard stalls reads of registers whose load is still outstanding. It sits between the warp scheduler/decoder (reads), the ALU writeback path and the LSU response path.

## Interface
- DATA_WIDTH, `DATA_WIDTH: register width.
- NUM_WARPS, 4: number of warp banks (≥1); WW = max(1,$clog2(NUM_WARPS)).
- NUM_REGS, 32: registers per warp (power of two, ≥4); AW = $clog2(NUM_REGS).
- PC_WIDTH, 8: width of pc input.
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- rd_req_valid  input  1  read request.
- rd_req_warp  input  WW  warp to read.
- rd_rs1_addr, rd_rs2_addr  input  AW each  source indices.
- rd_req_ready  output  1  request accepted this cycle.
- rd_rsp_valid  output  1  rs1/rs2 valid.
- rs1, rs2  output  DATA_WIDTH each  read data.
- wb_valid  input  1  core writeback.
- wb_warp  input  WW; wb_rd  input  AW; wb_mux  input  reg_input_mux_t.
- alu_out  input  DATA_WIDTH; immediate  input  DATA_WIDTH; pc  input  PC_WIDTH.
- pend_valid  input  1  mark (pend_warp, pend_rd) as awaiting LSU data.
- pend_warp  input  WW; pend_rd  input  AW.
- lsu_wb_valid  input  1  LSU return; lsu_wb_ready  output  1.
- lsu_wb_warp  input  WW; lsu_wb_rd  input  AW; lsu_wb_data  input  DATA_WIDTH.
- warp_execution_mask  output  NUM_WARPS×DATA_WIDTH  register 1 of every warp.
- err  output  1  sticky illegal-operation flag.

## Operation
- Register 0 of every warp reads zero. Writes to it are discarded, and pend_rd=0 is ignored.
- Register 1 is the execution mask: it resets to all ones and is writable like any other register.
- Port A write value by wb_mux:
  - ALU_OUT: alu_out.
  - IMMEDIATE: immediate.
  - PC_PLUS_1: zero-extended pc+1, wrapping at PC_WIDTH.
  - LSU_OUT or any other value: no write, err set.
- Port B writes lsu_wb_data and clears the pending bit of (lsu_wb_warp, lsu_wb_rd). It is accepted only when lsu_wb_valid && lsu_wb_ready.
- lsu_wb_ready = !(wb_valid && wb_warp==lsu_wb_warp && wb_rd==lsu_wb_rd). Only a same-register collision blocks the LSU; writes to different registers happen in the same cycle.
- Scoreboard: NUM_WARPS×NUM_REGS busy bits.
  - pend_valid sets the bit.
  - Port B acceptance clears it.
  - Set and clear of the same bit in one cycle leaves it set.
  - pend_valid on an already-busy register sets err; the bit stays set.
- Port A write to a busy register sets err and does not modify the busy bit.
- Read handshake: rd_req_ready = !busy[warp][rs1] && !busy[warp][rs2] (register 0 is never busy). A request is accepted when rd_req_valid && rd_req_ready.
- Bypass: reads accepted in the same cycle as a write to the same (warp, register) return the newly written value. Port A and port B are both forwarded.
- An out-of-range warp index (≥NUM_WARPS) on any port sets err and the operation is dropped.

## Timing
- Read latency 1: rd_rsp_valid and rs1/rs2 are registered and update the cycle after acceptance.
- rd_rsp_valid is a one-cycle pulse. rs1/rs2 hold their values until the next accepted read.
- Writes are visible to an unbypassed read one cycle after the write cycle.
- warp_execution_mask is registered state and reflects a write on the following cycle.
- rd_req_ready and lsu_wb_ready are combinational from the current inputs and busy bits.
- Reset values:
  - All registers 0 except register 1 = all ones.
  - Busy bits 0.
  - rd_rsp_valid 0, rs1/rs2 0, err 0.
- Reset mid-operation discards all pending loads. An LSU return after reset is written normally (no busy bit to clear).

## Structure
- Shared package (common.sv):
  - reg_input_mux_t (ALU_OUT, LSU_OUT, IMMEDIATE, PC_PLUS_1).
  - data_t.
  - Constants ZERO_REG=0, EXECUTION_MASK_REG=1.
- Sub-module reg_scoreboard holds the busy-bit array: set/clear ports, two combinational lookups, err output.
- Storage is a flat array indexed {warp, reg}.

## Test plan
- Reset, then read warp 2 r0/r1 -> rs1=0, rs2=all ones one cycle later; warp_execution_mask all ones for every warp.
- Port A IMMEDIATE 0x1234 to warp1 r5, with a same-cycle read of warp1 r5 -> rs1=0x1234 (bypass); warp0 r5 stays 0.
- pend warp3 r7, then read r7 -> rd_req_ready=0 until LSU returns 0xCAFE; next read gives 0xCAFE.
- Port A and LSU both target warp0 r4 -> lsu_wb_ready=0 and the port A value is stored. Repeat with r4 vs r6 -> both written.
- PC_PLUS_1 with pc=0xFF, PC_WIDTH=8 -> register = 0.
- Port A with wb_mux=LSU_OUT, and a write to r0 -> err=1 stays set, r0 reads 0.
